// File: rtl/load_store_unit.sv
// Load/store unit: bridges the core datapath to a word-wide data memory port
// with byte enables and a ready handshake, and reports misaligned, illegal and
// timed-out accesses.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault,
    output logic [1:0]  FaultCause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_f3;
    logic [1:0]         r_off;

    logic               w_valid;
    logic               w_illegal;
    logic               w_misalign;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_byte_sh;
    logic [31:0]        w_half_sh;
    logic [31:0]        w_ext;
    logic               w_timeout;

    // Request decode: legality, alignment and store lane placement.
    always_comb begin
        w_valid    = MemRead | MemWrite;
        w_illegal  = (MemRead & MemWrite)
                   | (MemRead  & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
                   | (MemWrite & (funct3 > 3'b010));
        w_misalign = ((funct3[1:0] == 2'b10) & (Addr[1:0] != 2'b00))
                   | ((funct3[1:0] == 2'b01) & Addr[0]);
        w_be       = 4'b1111;
        w_wdata    = WriteData;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << Addr[1:0];
                w_wdata = {4{WriteData[7:0]}};
            end
            2'b01: begin
                w_be    = Addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WriteData[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = WriteData;
            end
        endcase
    end

    // Load lane selection and sign/zero extension from the captured access.
    always_comb begin
        w_byte_sh = mem_rdata >> {r_off, 3'b000};
        w_half_sh = mem_rdata >> {r_off[1], 4'b0000};
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            3'b001:  w_ext = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            3'b100:  w_ext = {24'h000000, w_byte_sh[7:0]};
            3'b101:  w_ext = {16'h0000, w_half_sh[15:0]};
            default: w_ext = mem_rdata;
        endcase
        w_timeout = ((r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));
    end

    // Stall covers the accepting IDLE cycle and every REQ cycle, never reset.
    always_comb begin
        Stall = rst & (((r_state == S_IDLE) & w_valid) | (r_state == S_REQ));
    end

    // Access sequencer with registered memory-port and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_f3       <= '0;
            r_off      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            ReadData   <= '0;
            Fault      <= 1'b0;
            FaultCause <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    Fault      <= 1'b0;
                    FaultCause <= '0;
                    if (w_valid) begin
                        if (w_illegal) begin
                            r_state    <= S_DONE;
                            Fault      <= 1'b1;
                            FaultCause <= CAUSE_ILLEGAL;
                            ReadData   <= '0;
                        end else if (w_misalign) begin
                            r_state    <= S_DONE;
                            Fault      <= 1'b1;
                            FaultCause <= CAUSE_MISALIGN;
                            ReadData   <= '0;
                        end else begin
                            r_state   <= S_REQ;
                            r_cnt     <= '0;
                            r_f3      <= funct3;
                            r_off     <= Addr[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= {Addr[31:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        r_state    <= S_DONE;
                        mem_req    <= 1'b0;
                        ReadData   <= mem_we ? 32'h0 : w_ext;
                        Fault      <= 1'b0;
                        FaultCause <= '0;
                    end else if (w_timeout) begin
                        r_state    <= S_DONE;
                        mem_req    <= 1'b0;
                        ReadData   <= '0;
                        Fault      <= 1'b1;
                        FaultCause <= CAUSE_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    Fault      <= 1'b0;
                    FaultCause <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit, built with a short timeout of 4 cycles.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Fault;
    logic [1:0]  FaultCause;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .Addr       (Addr),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .Stall      (Stall),
        .Fault      (Fault),
        .FaultCause (FaultCause),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one access; ready is raised in REQ cycle rdy_at (0 = never).
    task automatic do_access(
        input  logic        mr,
        input  logic        mw,
        input  logic [2:0]  f3,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [31:0] rd,
        input  int          rdy_at,
        output int          n_stall,
        output int          n_req,
        output logic [31:0] c_addr,
        output logic [31:0] c_wdata,
        output logic [3:0]  c_be,
        output logic        c_we,
        output logic        c_fault,
        output logic [1:0]  c_cause,
        output logic [31:0] c_rdata,
        output logic        done_ok,
        output logic        stable_ok
    );
        n_stall   = 0;
        n_req     = 0;
        c_addr    = '0;
        c_wdata   = '0;
        c_be      = '0;
        c_we      = 1'b0;
        c_fault   = 1'b0;
        c_cause   = '0;
        c_rdata   = '0;
        done_ok   = 1'b0;
        stable_ok = 1'b1;
        @(posedge clk) #1;
        MemRead   = mr;
        MemWrite  = mw;
        funct3    = f3;
        Addr      = a;
        WriteData = wd;
        mem_rdata = rd;
        mem_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk) #1;
                mem_ready = mem_req && (rdy_at != 0) && ((n_req + 1) == rdy_at);
            end
            @(negedge clk);
            if (Stall) n_stall++;
            if (mem_req) begin
                n_req++;
                if (n_req == 1) begin
                    c_addr  = mem_addr;
                    c_wdata = mem_wdata;
                    c_be    = mem_be;
                    c_we    = mem_we;
                end else if (mem_addr !== c_addr || mem_wdata !== c_wdata ||
                             mem_be !== c_be || mem_we !== c_we) begin
                    stable_ok = 1'b0;
                end
            end
            if (c > 0 && !Stall) begin
                c_fault = Fault;
                c_cause = FaultCause;
                c_rdata = ReadData;
                done_ok = 1'b1;
                break;
            end
        end
        @(posedge clk) #1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mem_ready = 1'b0;
    endtask

    int          ns, nr;
    logic [31:0] ca, cw, crd;
    logic [3:0]  cb;
    logic        cwe, cf, dn, st;
    logic [1:0]  cc;

    initial begin
        rst       = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        funct3    = 3'b000;
        Addr      = '0;
        WriteData = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_stall",   32'(Stall), 32'h0);
        check("rst_rdata",   ReadData, 32'h0);
        check("rst_addr",    mem_addr, 32'h0);
        check("rst_cause",   32'(FaultCause), 32'h0);
        rst = 1'b1;

        // SW, ready immediately
        do_access(1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 1,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("sw_done",  32'(dn), 32'h1);
        check("sw_req",   32'(nr), 32'h1);
        check("sw_stall", 32'(ns), 32'h2);
        check("sw_addr",  ca, 32'h0000_1004);
        check("sw_be",    32'(cb), 32'hF);
        check("sw_we",    32'(cwe), 32'h1);
        check("sw_wdata", cw, 32'hDEAD_BEEF);
        check("sw_fault", 32'(cf), 32'h0);
        check("sw_fault_clr", 32'(Fault), 32'h0);

        // LB, ready on 3rd REQ cycle
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 3,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("lb_done",   32'(dn), 32'h1);
        check("lb_stall",  32'(ns), 32'h4);
        check("lb_be",     32'(cb), 32'h8);
        check("lb_we",     32'(cwe), 32'h0);
        check("lb_addr",   ca, 32'h0000_2000);
        check("lb_stable", 32'(st), 32'h1);
        check("lb_rdata",  crd, 32'hFFFF_FF80);

        do_access(1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 3,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("lbu_rdata", crd, 32'h0000_0080);

        // Half loads from the upper half
        do_access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h80FF_FF7F, 1,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("lh_rdata", crd, 32'hFFFF_80FF);
        check("lh_be",    32'(cb), 32'hC);
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_2000, 32'h0, 32'h80FF_FF7F, 1,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("lhu_rdata", crd, 32'h0000_FF7F);

        // SH
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 1,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("sh_wdata", cw, 32'hABCD_ABCD);
        check("sh_be",    32'(cb), 32'hC);
        check("sh_addr",  ca, 32'h0000_0100);

        // SB lane 1
        do_access(1'b0, 1'b1, 3'b000, 32'h0000_0105, 32'h0000_005A, 32'h0, 2,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("sb_wdata", cw, 32'h5A5A_5A5A);
        check("sb_be",    32'(cb), 32'h2);

        // Misaligned LW
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'hFFFF_FFFF, 1,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("mis_done",  32'(dn), 32'h1);
        check("mis_req",   32'(nr), 32'h0);
        check("mis_stall", 32'(ns), 32'h1);
        check("mis_fault", 32'(cf), 32'h1);
        check("mis_cause", 32'(cc), 32'h1);
        check("mis_rdata", crd, 32'h0);
        check("mis_pulse", 32'(Fault), 32'h0);

        // Illegal: read and write together, bad load funct3, bad store funct3
        do_access(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 32'h0, 1,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("ill_rw_cause", 32'(cc), 32'h3);
        check("ill_rw_req",   32'(nr), 32'h0);
        do_access(1'b1, 1'b0, 3'b011, 32'h0000_0001, 32'h0, 32'h0, 1,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("ill_ld_cause", 32'(cc), 32'h3);
        do_access(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 1,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("ill_st_cause", 32'(cc), 32'h3);

        // Timeout
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1122_3344, 0,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("to_done",  32'(dn), 32'h1);
        check("to_req",   32'(nr), 32'h4);
        check("to_stall", 32'(ns), 32'h5);
        check("to_fault", 32'(cf), 32'h1);
        check("to_cause", 32'(cc), 32'h2);
        check("to_rdata", crd, 32'h0);

        // Ready on the last allowed cycle wins
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1122_3344, 4,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("edge_req",   32'(nr), 32'h4);
        check("edge_fault", 32'(cf), 32'h0);
        check("edge_cause", 32'(cc), 32'h0);
        check("edge_rdata", crd, 32'h1122_3344);

        // Reset in the middle of REQ
        @(posedge clk) #1;
        MemRead = 1'b1;
        funct3  = 3'b010;
        Addr    = 32'h0000_0040;
        repeat (2) @(posedge clk);
        #2;
        check("mid_req_high", 32'(mem_req), 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_req",   32'(mem_req), 32'h0);
        check("mid_rst_stall", 32'(Stall), 32'h0);
        check("mid_rst_addr",  mem_addr, 32'h0);
        check("mid_rst_be",    32'(mem_be), 32'h0);
        check("mid_rst_fault", 32'(Fault), 32'h0);
        MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        do_access(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 2,
                  ns, nr, ca, cw, cb, cwe, cf, cc, crd, dn, st);
        check("post_done",  32'(dn), 32'h1);
        check("post_req",   32'(nr), 32'h2);
        check("post_stall", 32'(ns), 32'h3);
        check("post_addr",  ca, 32'h0000_0020);
        check("post_wdata", cw, 32'hCAFE_F00D);
        check("post_fault", 32'(cf), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
